// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared widths, stage record and per-instruction Tuse/Tnew
//                defaults for the MIPS hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int TW_DEF = 3;
    localparam int RW_DEF = 5;

    // All-ones Tuse marks an operand the instruction does not read.
    localparam logic [TW_DEF-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic              vld;
        logic [RW_DEF-1:0] dst;
        logic [TW_DEF-1:0] tnew;
    } stage_rec;

    localparam logic [TW_DEF-1:0] TUSE_ADDU_RS = 3'd1;
    localparam logic [TW_DEF-1:0] TUSE_ADDU_RT = 3'd1;
    localparam logic [TW_DEF-1:0] TNEW_ADDU    = 3'd1;
    localparam logic [TW_DEF-1:0] TUSE_SUBU_RS = 3'd1;
    localparam logic [TW_DEF-1:0] TUSE_SUBU_RT = 3'd1;
    localparam logic [TW_DEF-1:0] TNEW_SUBU    = 3'd1;
    localparam logic [TW_DEF-1:0] TUSE_ORI_RS  = 3'd1;
    localparam logic [TW_DEF-1:0] TNEW_ORI     = 3'd1;
    localparam logic [TW_DEF-1:0] TNEW_LUI     = 3'd1;
    localparam logic [TW_DEF-1:0] TUSE_LW_RS   = 3'd1;
    localparam logic [TW_DEF-1:0] TNEW_LW      = 3'd2;
    localparam logic [TW_DEF-1:0] TUSE_SW_RS   = 3'd1;
    localparam logic [TW_DEF-1:0] TUSE_SW_RT   = 3'd2;
    localparam logic [TW_DEF-1:0] TUSE_BEQ_RS  = 3'd0;
    localparam logic [TW_DEF-1:0] TUSE_BEQ_RT  = 3'd0;
    localparam logic [TW_DEF-1:0] TUSE_JR_RS   = 3'd0;
    localparam logic [TW_DEF-1:0] TNEW_JAL     = 3'd0;
    localparam logic [TW_DEF-1:0] TUSE_MD_RS   = 3'd1;
    localparam logic [TW_DEF-1:0] TUSE_MD_RT   = 3'd1;
    localparam logic [TW_DEF-1:0] TNEW_MFHI    = 3'd1;
    localparam logic [TW_DEF-1:0] TNEW_MFLO    = 3'd1;

endpackage

`default_nettype wire

// File: rtl/hazard_stage_reg.sv
// ============================================================================
//  Module      : hazard_stage_reg
//  Description : One tracked pipeline stage: bubble insert and saturating
//                Tnew decrement on the way in.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stage_reg #(
    parameter int RW  = 5,
    parameter int TW  = 3,
    parameter bit DEC = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bubble,
    input  logic          in_vld,
    input  logic [RW-1:0] in_dst,
    input  logic [TW-1:0] in_tnew,
    output logic          vld,
    output logic [RW-1:0] dst,
    output logic [TW-1:0] tnew
);

    logic          r_vld;
    logic [RW-1:0] r_dst;
    logic [TW-1:0] r_tnew;
    logic [TW-1:0] w_tnew_nxt;

    always_comb begin
        w_tnew_nxt = in_tnew;
        if (DEC && (in_tnew != '0)) begin
            w_tnew_nxt = in_tnew - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            r_vld  <= 1'b0;
            r_dst  <= '0;
            r_tnew <= '0;
        end else begin
            r_vld  <= in_vld;
            r_dst  <= in_dst;
            r_tnew <= w_tnew_nxt;
        end
    end

    assign vld  = r_vld;
    assign dst  = r_dst;
    assign tnew = r_tnew;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Tuse/Tnew hazard unit beside D: stall/flush and forwarding
//                selects; mult/div busy interlock when HAZARD_MD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE  = 3,
    parameter int NSRC    = 2,
    parameter int TW      = TW_DEF,
    parameter int RW      = RW_DEF,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    localparam int SW     = (NSTAGE > 0) ? $clog2(NSTAGE + 1) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC*RW-1:0] d_src,
    input  logic [NSRC*TW-1:0] d_tuse,
    input  logic [RW-1:0]      d_dst,
    input  logic               d_regwrite,
    input  logic [TW-1:0]      d_tnew,
    input  logic               d_md_start,
    input  logic               d_md_div,
    input  logic               d_md_use,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_e,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic               md_busy
);

    logic [NSTAGE-1:0] w_vld;
    logic [RW-1:0]     w_dst  [NSTAGE];
    logic [TW-1:0]     w_tnew [NSTAGE];
    logic [NSRC-1:0]   w_blocked;
    logic              w_data_stall;
    logic              w_md_stall;

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
            if (k == 0) begin : g_head
                // E entry: Tnew is already relative to E, so no decrement here.
                hazard_stage_reg #(.RW(RW), .TW(TW), .DEC(1'b0)) u_stage (
                    .clk     (clk),
                    .reset   (reset),
                    .bubble  (stall_d),
                    .in_vld  (d_regwrite),
                    .in_dst  (d_dst),
                    .in_tnew (d_tnew),
                    .vld     (w_vld[k]),
                    .dst     (w_dst[k]),
                    .tnew    (w_tnew[k])
                );
            end else begin : g_tail
                hazard_stage_reg #(.RW(RW), .TW(TW), .DEC(1'b1)) u_stage (
                    .clk     (clk),
                    .reset   (reset),
                    .bubble  (1'b0),
                    .in_vld  (w_vld[k-1]),
                    .in_dst  (w_dst[k-1]),
                    .in_tnew (w_tnew[k-1]),
                    .vld     (w_vld[k]),
                    .dst     (w_dst[k]),
                    .tnew    (w_tnew[k])
                );
            end
        end
    endgenerate

    // The youngest matching writer owns the operand: if it is not ready yet,
    // older ready copies are stale and must not be forwarded.
    always_comb begin
        w_data_stall = 1'b0;
        w_blocked    = '0;
        fwd_sel      = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (w_vld[k] && (w_dst[k] == d_src[i*RW +: RW]) && (d_src[i*RW +: RW] != '0)) begin
                    if (w_tnew[k] > d_tuse[i*TW +: TW]) begin
                        w_data_stall = 1'b1;
                    end
                    if (!w_blocked[i]) begin
                        w_blocked[i] = 1'b1;
                        if (w_tnew[k] == '0) begin
                            fwd_sel[i*SW +: SW] = SW'(k + 1);
                        end
                    end
                end
            end
        end
    end

`ifdef HAZARD_MD_EN
    localparam int CW = $clog2(DIV_LAT + 1);

    logic [CW-1:0] r_md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (d_md_start && !stall_d) begin
            r_md_cnt <= d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CW'(1);
        end
    end

    assign md_busy    = (r_md_cnt != '0);
    assign w_md_stall = d_md_use && md_busy;
`else
    logic w_md_unused;

    assign w_md_unused = ^{d_md_start, d_md_div, d_md_use, MUL_LAT != 0, DIV_LAT != 0};
    assign md_busy     = 1'b0;
    assign w_md_stall  = 1'b0;
`endif

    assign stall_d = w_data_stall | w_md_stall;
    assign stall_f = stall_d;
    assign flush_e = stall_d;

endmodule

`default_nettype wire
